// File: rtl/mips_pkg.sv
// mips_pkg: opcode constants and interrupt-controller FSM states shared across the pipeline
package mips_pkg;
  localparam logic [5:0] OP_RET = 6'b010000;
  localparam logic [5:0] OP_JMP = 6'b011000;
  localparam logic [3:0] OP_JCOND_PFX = 4'b0111;
  typedef enum logic [1:0] {IDLE, ISSUE, VECTOR, SERVICE} irq_state_t;
  function automatic logic is_redirect_op(input logic [5:0] op);
    return op == OP_RET || op == OP_JMP || op[5:2] == OP_JCOND_PFX;
  endfunction
endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// prio_enc: fixed-priority encoder, lowest set index wins
module prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_req,
  output logic [W-1:0] o_id,
  output logic         o_any
);
  always_comb begin
    o_id = '0;
    for (int i = N - 1; i >= 0; i--) if (i_req[i]) o_id = W'(i);
  end
  assign o_any = |i_req;
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-latched, masked, prioritised interrupt requester for jump control
module irq_ctrl
  import mips_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq,
  input  logic [5:0]       op,
  input  logic             pc_mux_sel,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  output logic             interrupt,
  output logic [ID_W-1:0]  irq_id,
  output logic             in_service,
  output logic [N_SRC-1:0] pending
);
  logic [N_SRC-1:0] r_pending, r_mask, r_irq_prev, w_rise, w_elig, w_ack;
  logic [ID_W-1:0]  r_irq_id, w_win;
  logic             r_interrupt, r_in_service, w_any, w_hold, w_go, w_ret;
  irq_state_t       r_state;
  prio_enc #(.N(N_SRC), .W(ID_W)) u_prio (.i_req(w_elig), .o_id(w_win), .o_any(w_any));
  assign w_rise = irq & ~r_irq_prev;
  assign w_elig = r_pending & r_mask;
  // a redirect in flight would overwrite the single saved return address
  assign w_hold = pc_mux_sel || is_redirect_op(op);
  assign w_go   = r_state == IDLE && w_any && !w_hold;
  assign w_ack  = w_go ? N_SRC'(1) << w_win : '0;
  assign w_ret  = r_state == SERVICE && op == OP_RET;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending    <= '0;
      r_mask       <= '0;
      r_irq_prev   <= '0;
      r_irq_id     <= '0;
      r_interrupt  <= 1'b0;
      r_in_service <= 1'b0;
      r_state      <= IDLE;
    end else begin
      r_irq_prev   <= irq;
      r_pending    <= (r_pending & ~w_ack) | w_rise;
      r_mask       <= mask_we ? mask_wdata : r_mask;
      r_irq_id     <= w_go ? w_win : r_irq_id;
      r_interrupt  <= w_go;
      r_in_service <= w_go || (r_in_service && !w_ret);
      r_state      <= w_go ? ISSUE :
                      r_state == ISSUE ? VECTOR :
                      r_state == VECTOR ? SERVICE :
                      w_ret ? IDLE : r_state;
    end
  end
  assign interrupt  = r_interrupt;
  assign irq_id     = r_irq_id;
  assign in_service = r_in_service;
  assign pending    = r_pending;
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed stimulus, per-cycle comparison against a behavioural model plus literal checks
module tb_irq_ctrl;
  localparam int N = 4;
  localparam logic [5:0] RET = 6'b010000;
  logic clk = 0, reset = 1, pc_mux_sel = 0, mask_we = 0;
  logic [N-1:0] irq = '0, mask_wdata = '0;
  logic [5:0] op = '0;
  logic interrupt, in_service;
  logic [1:0] irq_id;
  logic [N-1:0] pending;
  int n_chk = 0, n_err = 0, pulses;
  irq_ctrl #(.N_SRC(N), .ID_W(2)) dut (
    .clk(clk), .reset(reset), .irq(irq), .op(op), .pc_mux_sel(pc_mux_sel),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .interrupt(interrupt),
    .irq_id(irq_id), .in_service(in_service), .pending(pending)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  // model: pending set, mask, and an age counter measured from the interrupt pulse
  logic [N-1:0] m_pend, m_mask, m_prev;
  logic [1:0] m_id;
  logic m_svc, started = 0;
  int m_age;
  always @(posedge clk) begin
    if (reset) begin
      m_pend = '0; m_mask = '0; m_prev = '0; m_id = '0; m_svc = 0; m_age = 0;
    end else begin
      if (m_svc) begin
        if (m_age >= 2 && op == RET) m_svc = 0;
        else m_age++;
      end else if ((m_pend & m_mask) != 0 &&
                   !(pc_mux_sel || op == 6'b011000 || op[5:2] == 4'b0111 || op == RET)) begin
        for (int i = N - 1; i >= 0; i--) if (m_pend[i] && m_mask[i]) m_id = 2'(i);
        m_pend[m_id] = 1'b0;
        m_svc = 1;
        m_age = 0;
      end
      m_pend = m_pend | (irq & ~m_prev);
      m_prev = irq;
      if (mask_we) m_mask = mask_wdata;
    end
    started = 1;
  end
  always @(negedge clk) if (started) begin
    chk("model_interrupt", 32'(interrupt), 32'(m_svc && m_age == 0));
    chk("model_in_service", 32'(in_service), 32'(m_svc));
    chk("model_pending", 32'(pending), 32'(m_pend));
    if (m_svc) chk("model_irq_id", 32'(irq_id), 32'(m_id));
  end
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic ret_now();
    op = RET; tick(); op = '0;
  endtask
  initial begin
    tick(2);
    chk("reset_pending", 32'(pending), 0);
    chk("reset_interrupt", 32'(interrupt), 0);
    chk("reset_in_service", 32'(in_service), 0);
    chk("reset_irq_id", 32'(irq_id), 0);
    reset = 0;
    mask_we = 1; mask_wdata = 4'b1111; tick(); mask_we = 0;
    irq = 4'b0100; tick(); irq = '0;
    chk("t1_pending_set", 32'(pending), 32'h4);
    chk("t1_no_early_pulse", 32'(interrupt), 0);
    tick();
    chk("t1_pulse", 32'(interrupt), 1);
    chk("t1_id", 32'(irq_id), 2);
    chk("t1_acked", 32'(pending), 0);
    tick();
    chk("t1_one_cycle", 32'(interrupt), 0);
    tick(3);
    op = RET;
    chk("t1_svc_at_ret", 32'(in_service), 1);
    tick(); op = '0;
    chk("t1_svc_drop", 32'(in_service), 0);
    irq = 4'b1010; tick(); irq = '0; tick();
    chk("t2_first_id", 32'(irq_id), 1);
    chk("t2_first_pulse", 32'(interrupt), 1);
    tick(2); ret_now();
    chk("t2_idle_gap", 32'(interrupt), 0);
    tick();
    chk("t2_second_pulse", 32'(interrupt), 1);
    chk("t2_second_id", 32'(irq_id), 3);
    tick(2); ret_now();
    mask_we = 1; mask_wdata = 4'b1110; tick(); mask_we = 0;
    irq = 4'b0001; tick(); irq = '0; tick(2);
    chk("t3_masked_none", 32'(interrupt), 0);
    chk("t3_masked_pend", 32'(pending), 32'h1);
    mask_we = 1; mask_wdata = 4'b1111; tick(); mask_we = 0; tick();
    chk("t3_unmask_pulse", 32'(interrupt), 1);
    chk("t3_unmask_id", 32'(irq_id), 0);
    tick(2); ret_now();
    op = 6'b011000; irq = 4'b0100; tick(); irq = '0; tick(2);
    chk("t4_jmp_hold", 32'(interrupt), 0);
    op = '0; tick();
    chk("t4_jmp_release", 32'(interrupt), 1);
    tick(); op = RET; tick(); op = '0;
    chk("t4_vector_ret_ignored", 32'(in_service), 1);
    tick();
    chk("t4_still_service", 32'(in_service), 1);
    ret_now();
    chk("t4_svc_end", 32'(in_service), 0);
    pc_mux_sel = 1; irq = 4'b0010; tick(); irq = '0; tick(2);
    chk("t4_pcmux_hold", 32'(interrupt), 0);
    pc_mux_sel = 0; tick();
    chk("t4_pcmux_release", 32'(interrupt), 1);
    chk("t4_pcmux_id", 32'(irq_id), 1);
    tick(2); ret_now();
    op = 6'b011101; irq = 4'b1000; tick(); irq = '0; tick(2);
    chk("t4_jcond_hold", 32'(interrupt), 0);
    op = '0; tick(); tick(2); ret_now();
    pulses = 0;
    irq = 4'b0010;
    for (int i = 0; i < 10; i++) begin tick(); if (interrupt) pulses++; end
    irq = '0; ret_now();
    for (int i = 0; i < 3; i++) begin tick(); if (interrupt) pulses++; end
    chk("t5_level_one_pulse", 32'(pulses), 1);
    irq = 4'b0001; tick(); irq = '0; tick(3);
    chk("t6_in_service", 32'(in_service), 1);
    irq = 4'b0100; reset = 1; tick(); reset = 0; irq = '0;
    chk("t6_reset_svc", 32'(in_service), 0);
    chk("t6_reset_pend", 32'(pending), 0);
    irq = 4'b0001; tick(); irq = '0; tick(3);
    chk("t6_mask_cleared", 32'(interrupt), 0);
    chk("t6_pend_premask", 32'(pending), 32'h1);
    chk("t6_no_service", 32'(in_service), 0);
    tick(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
